// File: rtl/ant_sprite_blitter.sv
// Purpose: walks the rotated ant sprite row by row and serialises each row into clipped single-pixel framebuffer writes.
// Latency: blit takes 2305 cycles from start acceptance to the finished pulse, plus one cycle per cycle waiting for src_done.
// Backpressure: none; the framebuffer must take one write per cycle, and start is ignored unless idle.
module ant_sprite_blitter #(
    parameter int SPRITE_W = 47,
    parameter int SPRITE_H = 47,
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int ADDR_W   = 15,
    parameter int COLOR_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          pos_x,
    input  logic [6:0]          pos_y,
    input  logic [COLOR_W-1:0]  fg_color,
    input  logic                transparent,
    input  logic                src_done,
    output logic [9:0]          line_count,
    input  logic [SPRITE_W-1:0] line_data,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOR_W-1:0]  fb_data,
    output logic                fb_we,
    output logic                busy,
    output logic                finished
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SPRITE_H - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_SRC = 3'd1;
    localparam logic [2:0] S_ROW_WAIT = 3'd2;
    localparam logic [2:0] S_PIXEL    = 3'd3;
    localparam logic [2:0] S_FINISH   = 3'd4;

    logic [2:0]          r_state;
    logic [7:0]          r_pos_x;
    logic [6:0]          r_pos_y;
    logic [COLOR_W-1:0]  r_fg;
    logic                r_transp;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic                r_wait;
    logic [SPRITE_W-1:0] r_shift;
    logic [9:0]          r_line_count;

    logic [8:0]          w_x_sum;
    logic [7:0]          w_y_sum;
    logic                w_bit;
    logic                w_in_pixel;
    logic                w_on_screen;
    logic [ADDR_W-1:0]   w_addr;

    // Screen coordinates of the current pixel; sums are widened so an
    // off-screen position never wraps back onto the visible area.
    assign w_x_sum     = 9'(r_pos_x) + 9'(r_col);
    assign w_y_sum     = 8'(r_pos_y) + 8'(r_row);
    assign w_bit       = r_shift[SPRITE_W-1];
    assign w_in_pixel  = (r_state == S_PIXEL);
    assign w_on_screen = (w_x_sum < 9'(FB_W)) && (w_y_sum < 8'(FB_H));
    assign w_addr      = ADDR_W'(ADDR_W'(w_y_sum) * ADDR_W'(FB_W) + ADDR_W'(w_x_sum));

    assign line_count = r_line_count;
    assign busy       = (r_state != S_IDLE);
    assign finished   = (r_state == S_FINISH);

    // Blit sequencer: start capture, source handshake, row fetch wait and pixel walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pos_x      <= '0;
            r_pos_y      <= '0;
            r_fg         <= '0;
            r_transp     <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_wait       <= 1'b0;
            r_shift      <= '0;
            r_line_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pos_x      <= pos_x;
                        r_pos_y      <= pos_y;
                        r_fg         <= fg_color;
                        r_transp     <= transparent;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_line_count <= '0;
                        r_state      <= S_WAIT_SRC;
                    end
                end
                S_WAIT_SRC: begin
                    if (src_done) begin
                        r_wait  <= 1'b0;
                        r_state <= S_ROW_WAIT;
                    end
                end
                S_ROW_WAIT: begin
                    // Two cycles: the rotator samples line_count on the first
                    // edge and its registered row is valid on the second.
                    if (!r_wait) begin
                        r_wait <= 1'b1;
                    end else begin
                        r_wait  <= 1'b0;
                        r_shift <= line_data;
                        r_col   <= '0;
                        r_state <= S_PIXEL;
                    end
                end
                S_PIXEL: begin
                    // MSB is the leftmost column, so shift left each pixel.
                    r_shift <= r_shift << 1;
                    if (r_col == LAST_COL) begin
                        if (r_row != LAST_ROW) begin
                            r_row        <= r_row + 1'b1;
                            r_line_count <= 10'(r_row) + 10'd1;
                            r_wait       <= 1'b0;
                            r_state      <= S_ROW_WAIT;
                        end else begin
                            r_state <= S_FINISH;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Framebuffer write port: one pixel per PIXEL cycle, clipped and optionally transparent.
    always_comb begin
        fb_we   = 1'b0;
        fb_addr = '0;
        fb_data = '0;
        if (w_in_pixel) begin
            fb_addr = w_addr;
            fb_data = w_bit ? r_fg : '0;
            fb_we   = w_on_screen && (w_bit || !r_transp);
        end
    end

endmodule

// File: tb/tb_ant_sprite_blitter.sv
// Purpose: directed bench for ant_sprite_blitter with a registered stub rotator and a write scoreboard.
// Latency: each blit is tracked cycle by cycle from the start acceptance edge.
// Backpressure: none; every write strobe is consumed in the cycle it appears.
module tb_ant_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pos_x = '0;
    logic [6:0]  pos_y = '0;
    logic [2:0]  fg_color = '0;
    logic        transparent = 1'b0;
    logic        src_done = 1'b0;
    logic [9:0]  line_count;
    logic [46:0] line_data = '0;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        busy;
    logic        finished;

    int n_vec  = 0;
    int n_fail = 0;
    int mode   = 0;

    typedef struct {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] fg;
        logic       tr;
        int         mode;
        int         delay;
        int         poke_row;
        int         exp_writes;
        int         exp_first;
        int         exp_last;
        int         exp_fin;
    } vec_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    vec_t vecs[8];

    ant_sprite_blitter dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .fg_color    (fg_color),
        .transparent (transparent),
        .src_done    (src_done),
        .line_count  (line_count),
        .line_data   (line_data),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .busy        (busy),
        .finished    (finished)
    );

    always #5 clk = ~clk;

    // Sprite row patterns: 0 = leftmost pixel only, 1 = solid,
    // 2 = diagonal (row r lights column r), 3 = checkerboard.
    function automatic logic [46:0] pat(input int m, input int row);
        logic [46:0] p;
        p = '0;
        case (m)
            0: p[46] = 1'b1;
            1: p = '1;
            2: if (row >= 0 && row <= 46) p[46-row] = 1'b1;
            default: for (int c = 0; c < 47; c++) p[46-c] = ((row + c) % 2 == 0);
        endcase
        return p;
    endfunction

    // Stub rotator: row data registered one cycle after line_count.
    always @(posedge clk) line_data <= pat(mode, int'(line_count));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_blit(input vec_t v, input int idx);
        wr_t  q[$];
        wr_t  w;
        logic [46:0] p;
        int k, fin_k, busy_n, fin_n, wr_n, early, lc_bad, first, last, maxa;
        int x, y, poke_k;
        for (int r = 0; r < 47; r++) begin
            p = pat(v.mode, r);
            for (int c = 0; c < 47; c++) begin
                x = int'(v.px) + c;
                y = int'(v.py) + r;
                if (x < 160 && y < 120 && (p[46-c] || !v.tr)) begin
                    w.addr = y * 160 + x;
                    w.data = p[46-c] ? int'(v.fg) : 0;
                    q.push_back(w);
                end
            end
        end
        mode = v.mode;
        poke_k = (v.poke_row >= 0) ? v.delay + 1 + v.poke_row * 49 + 10 : -1;
        @(negedge clk);
        pos_x = v.px; pos_y = v.py; fg_color = v.fg; transparent = v.tr;
        start = 1'b1;
        src_done = (v.delay == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        pos_x = v.px ^ 8'h5a; pos_y = v.py ^ 7'h2b; fg_color = ~v.fg; transparent = ~v.tr;
        k = 0; fin_k = -1; busy_n = 0; fin_n = 0; wr_n = 0; early = 0; lc_bad = 0;
        first = -1; last = -1; maxa = -1;
        while (k < v.exp_fin + 20) begin
            @(negedge clk);
            k++;
            src_done = (k > v.delay);
            if (k == poke_k) begin
                start = 1'b1;
                pos_x = 8'd3;
                pos_y = 7'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (finished) begin
                fin_n++;
                if (fin_k < 0) fin_k = k;
            end
            if (k <= v.delay + 3) begin
                if (line_count != 10'd0) lc_bad++;
                if (fb_we) early++;
            end
            if (fb_we) begin
                wr_n++;
                if (first < 0) first = int'(fb_addr);
                last = int'(fb_addr);
                if (int'(fb_addr) > maxa) maxa = int'(fb_addr);
                if (q.size() == 0) begin
                    chk($sformatf("v%0d_extra_write_addr", idx), int'(fb_addr), -1);
                end else begin
                    w = q.pop_front();
                    chk($sformatf("v%0d_wr%0d_addr", idx, wr_n), int'(fb_addr), w.addr);
                    chk($sformatf("v%0d_wr%0d_data", idx, wr_n), int'(fb_data), w.data);
                end
            end
        end
        src_done = 1'b0;
        chk($sformatf("v%0d_write_count", idx), wr_n, v.exp_writes);
        chk($sformatf("v%0d_first_addr", idx), first, v.exp_first);
        chk($sformatf("v%0d_last_addr", idx), last, v.exp_last);
        chk($sformatf("v%0d_max_addr_in_fb", idx), int'(maxa <= 19199), 1);
        chk($sformatf("v%0d_missing_writes", idx), q.size(), 0);
        chk($sformatf("v%0d_finished_cycle", idx), fin_k, v.exp_fin);
        chk($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_fin);
        chk($sformatf("v%0d_finished_pulses", idx), fin_n, 1);
        chk($sformatf("v%0d_early_writes", idx), early, 0);
        chk($sformatf("v%0d_line_count_nonzero_in_wait", idx), lc_bad, 0);
    endtask

    initial begin
        int we_n, busy_n;
        //          px    py   fg  tr  mode delay poke writes first  last   fin
        vecs[0] = '{8'd0,   7'd0,   3'd5, 1'b1, 0, 0,   -1, 47,   0,     7360,  2305};
        vecs[1] = '{8'd130, 7'd100, 3'd6, 1'b0, 1, 0,   -1, 600,  16130, 19199, 2305};
        vecs[2] = '{8'd10,  7'd5,   3'd2, 1'b1, 2, 0,   -1, 47,   810,   8216,  2305};
        vecs[3] = '{8'd0,   7'd0,   3'd5, 1'b1, 0, 100, -1, 47,   0,     7360,  2405};
        vecs[4] = '{8'd10,  7'd5,   3'd2, 1'b1, 2, 0,   20, 47,   810,   8216,  2305};
        vecs[5] = '{8'd120, 7'd80,  3'd3, 1'b0, 3, 0,   -1, 1600, 12920, 19199, 2305};
        vecs[6] = '{8'd0,   7'd0,   3'd7, 1'b0, 1, 0,   -1, 2209, 0,     7406,  2305};
        vecs[7] = '{8'd150, 7'd110, 3'd1, 1'b1, 2, 0,   -1, 10,   17750, 19199, 2305};

        // Reset state, both while reset is held and once released with no start.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_line_count", int'(line_count), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_fb_we", int'(fb_we), 0);

        for (int i = 0; i < 8; i++) run_blit(vecs[i], i);

        // Reset in the middle of row 10, column 20 of a solid opaque blit.
        mode = 1;
        @(negedge clk);
        pos_x = 8'd0; pos_y = 7'd0; fg_color = 3'd4; transparent = 1'b0;
        src_done = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 514; k++) @(negedge clk);
        chk("mid_fb_we", int'(fb_we), 1);
        chk("mid_fb_addr", int'(fb_addr), 1620);
        chk("mid_fb_data", int'(fb_data), 4);
        chk("mid_line_count", int'(line_count), 10);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_fb_we", int'(fb_we), 0);
        chk("abort_line_count", int'(line_count), 0);
        chk("abort_finished", int'(finished), 0);
        reset = 1'b0;
        we_n = 0;
        busy_n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (fb_we) we_n++;
            if (busy) busy_n++;
        end
        src_done = 1'b0;
        chk("after_abort_writes", we_n, 0);
        chk("after_abort_busy", busy_n, 0);
        run_blit(vecs[6], 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
